axi4_s_w: RTL and testbench

- AXI4 write-channel slave. It accepts one AW burst, collects up to NBEAT W beats into an internal beat buffer, and presents the completed write to the host side (simulation bridge or host model) via a valid/ack handshake.
- Once the host acks, it returns the B response on the AXI side.
- It is the responder counterpart to the bridge's AXI4 write master. It sits on the QEMU PCIe bridge's inbound path: HDL initiator writes land here for forwarding to the host.

---
 rtl/axi4_bridge_pkg.sv | 26 ++
 rtl/axi4_beat_buf.sv | 43 ++++
 rtl/axi4_s_w.sv | 141 ++++++++++++++
 tb/tb_axi4_s_w.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axi4_bridge_pkg
// Brief   : Shared types and constants for the bridge AXI4 write slave.
// Rev     : 1.0
// ============================================================================
package axi4_bridge_pkg;

  localparam int TAGW_D = 3;
  localparam int ADRW_D = 64;
  localparam int DATW_D = 512;
  localparam int DTMP_D = 4096;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_HOLD = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/axi4_beat_buf.sv
`default_nettype none
// ============================================================================
// Module  : axi4_beat_buf
// Brief   : Beat buffer, one write port and a registered read port.
// Rev     : 1.0
// ============================================================================
module axi4_beat_buf #(
  parameter int NBEAT = 64,
  parameter int DATW  = 512,
  parameter int STBW  = DATW / 8,
  parameter int BCW   = $clog2(NBEAT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [BCW-1:0]  wr_addr,
  input  logic [DATW-1:0] wr_data,
  input  logic [STBW-1:0] wr_strb,
  input  logic [BCW-1:0]  rd_addr,
  output logic [DATW-1:0] rd_data,
  output logic [STBW-1:0] rd_strb
);

  logic [DATW+STBW-1:0] mem [NBEAT];

  // Storage carries no reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= {wr_strb, wr_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
      rd_strb <= '0;
    end else begin
      {rd_strb, rd_data} <= mem[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi4_s_w.sv
`default_nettype none
// ============================================================================
// Module  : axi4_s_w
// Brief   : AXI4 write slave; buffers one burst and hands it to the host.
// Rev     : 1.0
// ============================================================================
module axi4_s_w
  import axi4_bridge_pkg::*;
#(
  parameter int TAGW  = TAGW_D,
  parameter int ADRW  = ADRW_D,
  parameter int DATW  = DATW_D,
  parameter int STBW  = DATW / 8,
  parameter int DTMP  = DTMP_D,
  parameter int NBEAT = DTMP / STBW,
  parameter int BCW   = $clog2(NBEAT)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [TAGW-1:0] i_s_awid,
  input  logic [ADRW-1:0] i_s_awaddr,
  input  logic [7:0]      i_s_awlen,
  input  logic [2:0]      i_s_awsize,
  input  logic [1:0]      i_s_awburst,
  input  logic            i_s_awvalid,
  output logic            o_s_awready,
  input  logic [DATW-1:0] i_s_wdata,
  input  logic [STBW-1:0] i_s_wstrb,
  input  logic            i_s_wlast,
  input  logic            i_s_wvalid,
  output logic            o_s_wready,
  output logic [TAGW-1:0] o_s_bid,
  output logic [1:0]      o_s_bresp,
  output logic            o_s_bvalid,
  input  logic            i_s_bready,
  output logic [TAGW-1:0] o_req_id,
  output logic [ADRW-1:0] o_req_addr,
  output logic [7:0]      o_req_len,
  output logic [2:0]      o_req_size,
  output logic            o_req_valid,
  input  logic            i_req_ack,
  input  logic [1:0]      i_req_resp,
  input  logic [BCW-1:0]  i_rd_beat,
  output logic [DATW-1:0] o_rd_data,
  output logic [STBW-1:0] o_rd_strb
);

  state_t    r_state;
  state_t    w_nxt;
  logic [7:0] r_cnt;
  logic       r_err;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_at_len;
  logic w_beat_end;
  logic w_beat_err;
  logic w_aw_err;
  logic w_wr_en;
  logic w_to_err;

  assign w_aw_hs    = o_s_awready & i_s_awvalid;
  assign w_w_hs     = o_s_wready & i_s_wvalid;
  assign w_at_len   = (r_cnt == o_req_len);
  assign w_beat_end = w_w_hs & (w_at_len | i_s_wlast);
  // wlast early or missing at the final counted beat are the same mismatch.
  assign w_beat_err = w_w_hs & (i_s_wlast != w_at_len);
  assign w_to_err   = r_err | w_beat_err;
  assign w_aw_err   = (i_s_awburst != BURST_INCR) || (32'(i_s_awlen) >= NBEAT);
  assign w_wr_en    = w_w_hs && (32'(r_cnt) < NBEAT);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_aw_hs) w_nxt = ST_DATA;
      ST_DATA: if (w_beat_end) w_nxt = w_to_err ? ST_RESP : ST_HOLD;
      ST_HOLD: if (i_req_ack) w_nxt = ST_RESP;
      ST_RESP: if (i_s_bready) w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they are flop-driven.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      o_s_awready <= 1'b1;
      o_s_wready  <= 1'b0;
      o_req_valid <= 1'b0;
      o_s_bvalid  <= 1'b0;
      o_s_bresp   <= RESP_OKAY;
      o_req_id    <= '0;
      o_req_addr  <= '0;
      o_req_len   <= '0;
      o_req_size  <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      o_s_awready <= (w_nxt == ST_IDLE);
      o_s_wready  <= (w_nxt == ST_DATA);
      o_req_valid <= (w_nxt == ST_HOLD);
      o_s_bvalid  <= (w_nxt == ST_RESP);
      if (w_aw_hs) begin
        o_req_id   <= i_s_awid;
        o_req_addr <= i_s_awaddr;
        o_req_len  <= i_s_awlen;
        o_req_size <= i_s_awsize;
        r_cnt      <= '0;
        r_err      <= w_aw_err;
      end
      if (w_w_hs) begin
        r_cnt <= r_cnt + 8'd1;
        if (w_beat_err) r_err <= 1'b1;
      end
      if (r_state == ST_DATA && w_beat_end && w_to_err) o_s_bresp <= RESP_SLVERR;
      if (r_state == ST_HOLD && i_req_ack) o_s_bresp <= i_req_resp;
    end
  end

  assign o_s_bid = o_req_id;

  axi4_beat_buf #(
    .NBEAT (NBEAT),
    .DATW  (DATW),
    .STBW  (STBW),
    .BCW   (BCW)
  ) u_buf (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .wr_en   (w_wr_en),
    .wr_addr (r_cnt[BCW-1:0]),
    .wr_data (i_s_wdata),
    .wr_strb (i_s_wstrb),
    .rd_addr (i_rd_beat),
    .rd_data (o_rd_data),
    .rd_strb (o_rd_strb)
  );

endmodule
`default_nettype wire

// File: tb/tb_axi4_s_w.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi4_s_w
// Brief   : Directed, table-driven bench for the AXI4 write slave.
// Rev     : 1.0
// ============================================================================
module tb_axi4_s_w;

  localparam int DATW  = 512;
  localparam int STBW  = 64;
  localparam int NBEAT = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2:0]        awid;
  logic [63:0]       awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic [DATW-1:0]   wdata;
  logic [STBW-1:0]   wstrb;
  logic              wlast;
  logic              wvalid;
  logic              bready;
  logic              req_ack;
  logic [1:0]        req_resp;
  logic [5:0]        rd_beat;

  logic              o_s_awready, o_s_wready, o_s_bvalid, o_req_valid;
  logic [2:0]        o_s_bid, o_req_id, o_req_size;
  logic [1:0]        o_s_bresp;
  logic [63:0]       o_req_addr;
  logic [7:0]        o_req_len;
  logic [DATW-1:0]   o_rd_data;
  logic [STBW-1:0]   o_rd_strb;

  int errors = 0;
  int checks = 0;
  int req_cycles = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (o_req_valid) req_cycles <= req_cycles + 1;

  axi4_s_w dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_s_awid    (awid),
    .i_s_awaddr  (awaddr),
    .i_s_awlen   (awlen),
    .i_s_awsize  (awsize),
    .i_s_awburst (awburst),
    .i_s_awvalid (awvalid),
    .o_s_awready (o_s_awready),
    .i_s_wdata   (wdata),
    .i_s_wstrb   (wstrb),
    .i_s_wlast   (wlast),
    .i_s_wvalid  (wvalid),
    .o_s_wready  (o_s_wready),
    .o_s_bid     (o_s_bid),
    .o_s_bresp   (o_s_bresp),
    .o_s_bvalid  (o_s_bvalid),
    .i_s_bready  (bready),
    .o_req_id    (o_req_id),
    .o_req_addr  (o_req_addr),
    .o_req_len   (o_req_len),
    .o_req_size  (o_req_size),
    .o_req_valid (o_req_valid),
    .i_req_ack   (req_ack),
    .i_req_resp  (req_resp),
    .i_rd_beat   (rd_beat),
    .o_rd_data   (o_rd_data),
    .o_rd_strb   (o_rd_strb)
  );

  typedef struct {
    logic [2:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          nbeats;
    logic [63:0] last_strb;
    logic [7:0]  dbase;
    int          gap;
    logic [1:0]  hresp;
    bit          exp_req;
    logic [1:0]  exp_bresp;
    int          bdelay;
  } vec_t;

  vec_t vecs [7];

  function automatic vec_t mk(input logic [2:0] id, input logic [63:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                              input logic [63:0] lstrb, input logic [7:0] dbase, input int gap,
                              input logic [1:0] hresp, input bit exp_req, input logic [1:0] exp_bresp,
                              input int bdelay);
    vec_t v;
    v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.nbeats = nbeats; v.last_strb = lstrb; v.dbase = dbase; v.gap = gap;
    v.hresp = hresp; v.exp_req = exp_req; v.exp_bresp = exp_bresp; v.bdelay = bdelay;
    return v;
  endfunction

  function automatic logic [DATW-1:0] beat_data(input logic [7:0] base, input int i);
    logic [7:0] b;
    b = base + 8'(i);
    return {64{b}};
  endfunction

  task automatic chk(input string nm, input logic [DATW-1:0] act, input logic [DATW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting", nm);
  endtask

  task automatic send_beat(input logic [DATW-1:0] d, input logic [STBW-1:0] s, input logic l);
    int t = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    while (!o_s_wready && t < 20) begin @(negedge clk); t++; end
    if (!o_s_wready) timeout("wready");
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic send_aw(input logic [2:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    while (!o_s_awready && t < 20) begin @(negedge clk); t++; end
    if (!o_s_awready) timeout("awready");
    @(negedge clk);
    awvalid = 1'b0;
    chk("awready_busy", 512'(o_s_awready), 512'(0));
  endtask

  task automatic run_burst(input vec_t v, input int tag);
    int r0;
    int t;
    int nrd;
    logic [STBW-1:0] es;
    r0 = req_cycles;
    send_aw(v.id, v.addr, v.len, v.size, v.burst);
    for (int i = 0; i < v.nbeats; i++) begin
      if (i > 0) repeat (v.gap) @(negedge clk);
      chk($sformatf("v%0d_req_early_b%0d", tag, i), 512'(o_req_valid), 512'(0));
      send_beat(beat_data(v.dbase, i), (i == v.nbeats - 1) ? v.last_strb : {STBW{1'b1}},
                (i == v.nbeats - 1));
    end
    if (v.exp_req) begin
      t = 0;
      while (!o_req_valid && t < 20) begin @(negedge clk); t++; end
      if (!o_req_valid) timeout($sformatf("v%0d_req_valid", tag));
      chk($sformatf("v%0d_req_id", tag),   512'(o_req_id),   512'(v.id));
      chk($sformatf("v%0d_req_addr", tag), 512'(o_req_addr), 512'(v.addr));
      chk($sformatf("v%0d_req_len", tag),  512'(o_req_len),  512'(v.len));
      chk($sformatf("v%0d_req_size", tag), 512'(o_req_size), 512'(v.size));
      nrd = (v.nbeats < NBEAT) ? v.nbeats : NBEAT;
      for (int b = 0; b < nrd; b++) begin
        rd_beat = 6'(b);
        @(negedge clk);
        es = (b == v.nbeats - 1) ? v.last_strb : {STBW{1'b1}};
        chk($sformatf("v%0d_rd_data_%0d", tag, b), o_rd_data, beat_data(v.dbase, b));
        chk($sformatf("v%0d_rd_strb_%0d", tag, b), 512'(o_rd_strb), 512'(es));
        chk($sformatf("v%0d_req_hold_%0d", tag, b), 512'(o_req_valid), 512'(1));
      end
      req_ack = 1'b1; req_resp = v.hresp;
      @(negedge clk);
      req_ack = 1'b0; req_resp = 2'b00;
      chk($sformatf("v%0d_req_drop", tag), 512'(o_req_valid), 512'(0));
      chk($sformatf("v%0d_bvalid_next", tag), 512'(o_s_bvalid), 512'(1));
    end
    t = 0;
    while (!o_s_bvalid && t < 20) begin @(negedge clk); t++; end
    if (!o_s_bvalid) timeout($sformatf("v%0d_bvalid", tag));
    chk($sformatf("v%0d_bid", tag),   512'(o_s_bid),   512'(v.id));
    chk($sformatf("v%0d_bresp", tag), 512'(o_s_bresp), 512'(v.exp_bresp));
    for (int d = 0; d < v.bdelay; d++) begin
      @(negedge clk);
      chk($sformatf("v%0d_bvalid_hold_%0d", tag, d), 512'(o_s_bvalid), 512'(1));
      chk($sformatf("v%0d_bresp_hold_%0d", tag, d), 512'(o_s_bresp), 512'(v.exp_bresp));
      chk($sformatf("v%0d_bid_hold_%0d", tag, d), 512'(o_s_bid), 512'(v.id));
      chk($sformatf("v%0d_awready_low_%0d", tag, d), 512'(o_s_awready), 512'(0));
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk($sformatf("v%0d_bvalid_drop", tag), 512'(o_s_bvalid), 512'(0));
    chk($sformatf("v%0d_awready_back", tag), 512'(o_s_awready), 512'(1));
    chk($sformatf("v%0d_saw_req", tag), 512'(req_cycles != r0), 512'(v.exp_req));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk(3'd5, 64'h1000, 8'd0,  3'd6, 2'b01, 1,  {STBW{1'b1}}, 8'hA5, 0, 2'b00, 1'b1, 2'b00, 0);
    vecs[1] = mk(3'd2, 64'h2000, 8'd3,  3'd6, 2'b01, 4,  {STBW{1'b1}}, 8'h10, 2, 2'b00, 1'b1, 2'b00, 0);
    vecs[2] = mk(3'd7, 64'h4000, 8'd63, 3'd6, 2'b01, 64, 64'h0F,       8'h40, 0, 2'b00, 1'b1, 2'b00, 5);
    vecs[3] = mk(3'd1, 64'h5000, 8'd0,  3'd6, 2'b00, 1,  {STBW{1'b1}}, 8'h70, 0, 2'b00, 1'b0, 2'b10, 0);
    vecs[4] = mk(3'd3, 64'h6000, 8'd64, 3'd6, 2'b01, 65, {STBW{1'b1}}, 8'h80, 0, 2'b00, 1'b0, 2'b10, 0);
    vecs[5] = mk(3'd4, 64'h7000, 8'd3,  3'd6, 2'b01, 2,  {STBW{1'b1}}, 8'hC0, 0, 2'b00, 1'b0, 2'b10, 0);
    vecs[6] = mk(3'd6, 64'h8040, 8'd1,  3'd3, 2'b01, 2,  64'hFF,       8'hD0, 1, 2'b01, 1'b1, 2'b01, 1);

    rst_n = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    req_ack = 1'b0; req_resp = '0; rd_beat = '0;
    repeat (2) @(negedge clk);
    chk("rst_awready",   512'(o_s_awready), 512'(1));
    chk("rst_wready",    512'(o_s_wready),  512'(0));
    chk("rst_bvalid",    512'(o_s_bvalid),  512'(0));
    chk("rst_req_valid", 512'(o_req_valid), 512'(0));
    chk("rst_bresp",     512'(o_s_bresp),   512'(0));
    chk("rst_bid",       512'(o_s_bid),     512'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 7; k++) run_burst(vecs[k], k);

    // Reset during the third beat of a four-beat burst.
    send_aw(3'd2, 64'h9000, 8'd3, 3'd6, 2'b01);
    send_beat(beat_data(8'h20, 0), {STBW{1'b1}}, 1'b0);
    send_beat(beat_data(8'h20, 1), {STBW{1'b1}}, 1'b0);
    wdata = beat_data(8'h20, 2); wstrb = {STBW{1'b1}}; wvalid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_awready",   512'(o_s_awready), 512'(1));
    chk("midrst_wready",    512'(o_s_wready),  512'(0));
    chk("midrst_bvalid",    512'(o_s_bvalid),  512'(0));
    chk("midrst_req_valid", 512'(o_req_valid), 512'(0));
    @(negedge clk);
    wvalid = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_b",   512'(o_s_bvalid),  512'(0));
    chk("midrst_no_req", 512'(o_req_valid), 512'(0));
    chk("midrst_idle",   512'(o_s_awready), 512'(1));
    run_burst(vecs[0], 99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
